sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter PHASE_CYCLES, default 2: cycles spent on each 16-bit half-word access; legal range 1..15.
REQ-002 Parameter BASE_ADDR, default 1024: byte address mapped to SRAM word 0.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rd_en  input  1  memory-stage load request.
REQ-006 wr_en  input  1  memory-stage store request.
REQ-007 address  input  32  byte address from the memory stage.
REQ-008 write_data  input  32  store data.
REQ-009 read_data  output  32  load result; holds its value until the next read completes.
REQ-010 ready  output  1  low = stall the pipeline (freeze); high = no request pending, or request completing this cycle.
REQ-011 SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SRAM_ADDR  output  18  SRAM half-word address.
REQ-013 SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  output  1 each  active-low SRAM strobes.

Function
REQ-014 FSM states: IDLE, LO, HI, DONE.
REQ-015 IDLE with wr_en or rd_en high: latch address, write_data and operation; go to LO; phase counter = 0.
REQ-016 wr_en and rd_en both high: the write SHALL be performed and the read ignored.
REQ-017 Word index W = (address - BASE_ADDR) >> 2, truncated to 17 bits; address[1:0] ignored.
REQ-018 LO: SRAM_ADDR = {W,1'b0}; HI: SRAM_ADDR = {W,1'b1}.
REQ-019 LO/HI each last exactly PHASE_CYCLES cycles, counted by the phase counter; the counter resets at each phase entry.
REQ-020 Read phases: OE_N = 0, WE_N = 1, DQ released (high-Z); SRAM_DQ sampled on the last cycle of the phase; LO → read_data[15:0], HI → read_data[31:16].
REQ-021 Write phases: WE_N = 0, OE_N = 1; DQ driven with latched data[15:0] in LO and data[31:16] in HI.
REQ-022 CE_N, UB_N, LB_N = 0 in LO and HI; all strobes = 1 in IDLE and DONE.
REQ-023 DQ driven only during write phases; high-Z otherwise.
REQ-024 SRAM_ADDR = 0 in IDLE and DONE.
REQ-025 DONE lasts one cycle, then IDLE; a new request is accepted only from IDLE.
REQ-026 ready = ~((rd_en | wr_en) & state != DONE), combinational.
REQ-027 Latency with PHASE_CYCLES = P: ready rises 2P+1 cycles after the request is first seen in IDLE, and stays high for 1 cycle.
REQ-028 A request dropped after acceptance: the access SHALL still complete; latched inputs are unaffected by later input changes.
REQ-029 A request held high after DONE starts a new access on the next IDLE cycle; the memory stage deasserts it via pipeline advance.
REQ-030 address below BASE_ADDR: W wraps modulo 2^17, with no error indication.

Reset
REQ-031 rst low (asynchronous): state = IDLE, phase counter = 0, read_data = 0, all strobes = 1, SRAM_ADDR = 0, DQ = high-Z.
REQ-032 Reset during LO/HI aborts the access; a write may be partially committed (LO half only).
REQ-033 After rst rises, ready follows REQ-026 from state IDLE.

Verification
REQ-034 Reset, then wr_en = 1, address = 1024, write_data = 0xDEADBEEF, P = 2:
- ready low for cycles 0..4, high in cycle 5.
- SRAM word 0 = 0xBEEF, word 1 = 0xDEAD.
REQ-035 Then rd_en = 1, address = 1024: ready high in cycle 5; read_data = 0xDEADBEEF.
REQ-036 rd_en = wr_en = 1, address = 1028, write_data = 0x12345678: write occurs at SRAM half-words 2/3; read_data unchanged.
REQ-037 wr_en pulsed 1 cycle only: full write completes; ready stays high throughout, since no request is present.
REQ-038 rst low during HI of a read: strobes = 1 and DQ = Z immediately; read_data = 0; next read behaves per REQ-035.
REQ-039 P = 1, back-to-back reads at 1024 then 1032 held continuously: ready pulses every 4 cycles; data matches the SRAM contents.

Source files
------------

// File: rtl/sram_controller_if.sv
// -----------------------------------------------------------------------------
// sram_controller_if
// Memory-stage bus between the pipeline and the SRAM controller.
//   rd_en, wr_en  : load / store request, held by the memory stage
//   address       : byte address of the access
//   write_data    : store data
//   read_data     : load result, held until the next read completes
//   ready         : low = stall the pipeline, high = idle or completing
// The pipeline side uses the master modport, the controller the slave modport.
// -----------------------------------------------------------------------------
interface sram_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en,
        output wr_en,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  rd_en,
        input  wr_en,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );
endinterface

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
// Turns one 32-bit load/store from the memory stage into two 16-bit SRAM
// accesses (low half-word, then high half-word), stalling the pipeline until
// the access completes.
// Ports:
//   clk        : single clock, rising edge
//   rst        : asynchronous reset, active low
//   bus        : memory-stage bus (sram_controller_if.slave)
//   SRAM_DQ    : bidirectional 16-bit SRAM data bus
//   SRAM_ADDR  : SRAM half-word address
//   SRAM_*_N   : active-low SRAM strobes
// Parameters:
//   PHASE_CYCLES : cycles per half-word phase (1..15)
//   BASE_ADDR    : byte address mapped to SRAM word 0
// -----------------------------------------------------------------------------
module sram_controller #(
    parameter int unsigned PHASE_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR    = 32'd1024
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave bus,
    inout  wire  [15:0]      SRAM_DQ,
    output logic [17:0]      SRAM_ADDR,
    output logic             SRAM_UB_N,
    output logic             SRAM_LB_N,
    output logic             SRAM_WE_N,
    output logic             SRAM_CE_N,
    output logic             SRAM_OE_N
);

    localparam logic [3:0] LAST_CNT = 4'(PHASE_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [3:0]  phase_cnt_r;
    logic [3:0]  next_cnt_s;
    logic        op_write_r;
    logic        next_write_s;
    logic [16:0] word_r;
    logic [16:0] next_word_s;
    logic [31:0] wdata_r;
    logic [31:0] next_wdata_s;
    logic [31:0] read_data_r;
    logic        phase_last_s;

    // Pin registers: loaded from the next-state decode so the pins change in
    // the same cycle the FSM enters a phase, without decode glitches.
    logic [17:0] sram_addr_r;
    logic [17:0] next_addr_s;
    logic        strobe_n_r;
    logic        next_strobe_n_s;
    logic        we_n_r;
    logic        next_we_n_s;
    logic        oe_n_r;
    logic        next_oe_n_s;
    logic        dq_oe_r;
    logic        next_dq_oe_s;
    logic [15:0] dq_out_r;
    logic [15:0] next_dq_s;

    // State register and latched request fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            phase_cnt_r <= 4'd0;
            op_write_r  <= 1'b0;
            word_r      <= 17'd0;
            wdata_r     <= 32'd0;
        end else begin
            state_r     <= next_state_s;
            phase_cnt_r <= next_cnt_s;
            op_write_r  <= next_write_s;
            word_r      <= next_word_s;
            wdata_r     <= next_wdata_s;
        end
    end

    // Next-state, phase counter and request latch decode
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = phase_cnt_r;
        next_write_s = op_write_r;
        next_word_s  = word_r;
        next_wdata_s = wdata_r;
        phase_last_s = (phase_cnt_r == LAST_CNT);
        case (state_r)
            IDLE: begin
                next_cnt_s = 4'd0;
                if (bus.rd_en || bus.wr_en) begin
                    next_state_s = LO;
                    // A store wins when both requests are raised together.
                    next_write_s = bus.wr_en;
                    // Wraps modulo 2^17 for addresses below BASE_ADDR.
                    next_word_s  = 17'((bus.address - BASE_ADDR) >> 2);
                    next_wdata_s = bus.write_data;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LO: begin
                if (phase_last_s) begin
                    next_state_s = HI;
                    next_cnt_s   = 4'd0;
                end else begin
                    next_cnt_s   = phase_cnt_r + 4'd1;
                end
            end
            HI: begin
                if (phase_last_s) begin
                    next_state_s = DONE;
                    next_cnt_s   = 4'd0;
                end else begin
                    next_cnt_s   = phase_cnt_r + 4'd1;
                end
            end
            DONE: begin
                next_state_s = IDLE;
                next_cnt_s   = 4'd0;
            end
            default: begin
                next_state_s = IDLE;
                next_cnt_s   = 4'd0;
            end
        endcase
    end

    // SRAM pin values for the state being entered
    always_comb begin
        next_addr_s     = 18'd0;
        next_strobe_n_s = 1'b1;
        next_we_n_s     = 1'b1;
        next_oe_n_s     = 1'b1;
        next_dq_oe_s    = 1'b0;
        next_dq_s       = 16'd0;
        case (next_state_s)
            LO: begin
                next_addr_s     = {next_word_s, 1'b0};
                next_strobe_n_s = 1'b0;
                if (next_write_s) begin
                    next_we_n_s  = 1'b0;
                    next_dq_oe_s = 1'b1;
                    next_dq_s    = next_wdata_s[15:0];
                end else begin
                    next_oe_n_s  = 1'b0;
                end
            end
            HI: begin
                next_addr_s     = {next_word_s, 1'b1};
                next_strobe_n_s = 1'b0;
                if (next_write_s) begin
                    next_we_n_s  = 1'b0;
                    next_dq_oe_s = 1'b1;
                    next_dq_s    = next_wdata_s[31:16];
                end else begin
                    next_oe_n_s  = 1'b0;
                end
            end
            default: begin
                next_addr_s     = 18'd0;
                next_strobe_n_s = 1'b1;
            end
        endcase
    end

    // SRAM pin registers; reset releases the bus and deasserts every strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_addr_r <= 18'd0;
            strobe_n_r  <= 1'b1;
            we_n_r      <= 1'b1;
            oe_n_r      <= 1'b1;
            dq_oe_r     <= 1'b0;
            dq_out_r    <= 16'd0;
        end else begin
            sram_addr_r <= next_addr_s;
            strobe_n_r  <= next_strobe_n_s;
            we_n_r      <= next_we_n_s;
            oe_n_r      <= next_oe_n_s;
            dq_oe_r     <= next_dq_oe_s;
            dq_out_r    <= next_dq_s;
        end
    end

    // Read capture: SRAM_DQ is sampled on the last cycle of each read phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data_r <= 32'd0;
        end else if (!op_write_r && phase_last_s && (state_r == LO)) begin
            read_data_r[15:0] <= SRAM_DQ;
        end else if (!op_write_r && phase_last_s && (state_r == HI)) begin
            read_data_r[31:16] <= SRAM_DQ;
        end else begin
            read_data_r <= read_data_r;
        end
    end

    assign SRAM_DQ   = dq_oe_r ? dq_out_r : 16'bzzzz_zzzz_zzzz_zzzz;
    assign SRAM_ADDR = sram_addr_r;
    assign SRAM_CE_N = strobe_n_r;
    assign SRAM_UB_N = strobe_n_r;
    assign SRAM_LB_N = strobe_n_r;
    assign SRAM_WE_N = we_n_r;
    assign SRAM_OE_N = oe_n_r;

    assign bus.read_data = read_data_r;
    // Stall while a request is present, except in the completing cycle.
    assign bus.ready = ~((bus.rd_en | bus.wr_en) & (state_r != DONE));

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
// Bench for sram_controller: one instance with PHASE_CYCLES = 2 and one with
// PHASE_CYCLES = 1, each attached to a small behavioural SRAM. Expected load
// results are queued when a request is driven and compared when ready rises.
// -----------------------------------------------------------------------------
module tb_sram_controller;

    logic clk;
    logic rst;

    sram_controller_if bus0();
    sram_controller_if bus1();

    wire  [15:0] dq0;
    logic [17:0] addr0;
    logic        ub_n0, lb_n0, we_n0, ce_n0, oe_n0;
    wire  [15:0] dq1;
    logic [17:0] addr1;
    logic        ub_n1, lb_n1, we_n1, ce_n1, oe_n1;

    logic [15:0] mem0 [0:255];
    logic [15:0] mem1 [0:255];

    logic [15:0] exp_mem [logic [17:0]];
    logic [31:0] exp_rd;
    logic [31:0] sb_q  [$];
    logic [31:0] sb1_q [$];

    int n_checks;
    int n_pass;

    sram_controller #(.PHASE_CYCLES(2), .BASE_ADDR(32'd1024)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave),
        .SRAM_DQ(dq0), .SRAM_ADDR(addr0),
        .SRAM_UB_N(ub_n0), .SRAM_LB_N(lb_n0), .SRAM_WE_N(we_n0),
        .SRAM_CE_N(ce_n0), .SRAM_OE_N(oe_n0)
    );

    sram_controller #(.PHASE_CYCLES(1), .BASE_ADDR(32'd1024)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave),
        .SRAM_DQ(dq1), .SRAM_ADDR(addr1),
        .SRAM_UB_N(ub_n1), .SRAM_LB_N(lb_n1), .SRAM_WE_N(we_n1),
        .SRAM_CE_N(ce_n1), .SRAM_OE_N(oe_n1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAMs: drive DQ while read-enabled, store on write strobe
    assign dq0 = (!ce_n0 && !oe_n0 && we_n0) ? mem0[addr0[7:0]] : 16'bzzzz_zzzz_zzzz_zzzz;
    assign dq1 = (!ce_n1 && !oe_n1 && we_n1) ? mem1[addr1[7:0]] : 16'bzzzz_zzzz_zzzz_zzzz;

    always @(posedge clk) begin
        if (!ce_n0 && !we_n0) begin
            mem0[addr0[7:0]] <= dq0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One request on DUT0 (P = 2), held until ready, checking pins and latency
    task automatic access0(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] data, input string tag);
        logic [16:0] wi;
        logic [4:0]  exp_pins;
        bit          seen;
        wi = 17'((addr - 32'd1024) >> 2);
        if (wr) begin
            exp_mem[{wi, 1'b0}] = data[15:0];
            exp_mem[{wi, 1'b1}] = data[31:16];
            exp_pins = 5'b00001;
        end else begin
            exp_rd = {exp_mem[{wi, 1'b1}], exp_mem[{wi, 1'b0}]};
            exp_pins = 5'b00010;
        end
        sb_q.push_back(exp_rd);
        @(posedge clk); #1;
        bus0.wr_en = wr;
        bus0.rd_en = rd;
        bus0.address = addr;
        bus0.write_data = data;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 2) check_eq({tag, " addr lo"}, {14'd0, addr0}, {14'd0, wi, 1'b0});
            if (k >= 3 && k <= 4) check_eq({tag, " addr hi"}, {14'd0, addr0}, {14'd0, wi, 1'b1});
            if (k >= 1 && k <= 4) check_eq({tag, " strobes"}, {27'd0, ce_n0, ub_n0, lb_n0, we_n0, oe_n0}, {27'd0, exp_pins});
            if (bus0.ready) begin
                seen = 1'b1;
                check_eq({tag, " latency"}, 32'(k), 32'd5);
                check_eq({tag, " read_data"}, bus0.read_data, sb_q.pop_front());
            end
        end
        if (!seen) check_eq({tag, " ready timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        bus0.wr_en = 1'b0;
        bus0.rd_en = 1'b0;
    endtask

    initial begin
        int last;
        int pulses;
        n_checks = 0;
        n_pass = 0;
        exp_rd = 32'd0;
        rst = 1'b0;
        bus0.rd_en = 1'b0; bus0.wr_en = 1'b0; bus0.address = 32'd0; bus0.write_data = 32'd0;
        bus1.rd_en = 1'b0; bus1.wr_en = 1'b0; bus1.address = 32'd0; bus1.write_data = 32'd0;
        for (int i = 0; i < 256; i++) mem1[i] = 16'd0;
        mem1[0] = 16'h1111; mem1[1] = 16'h2222;
        mem1[4] = 16'h3333; mem1[5] = 16'h4444;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset strobes", {27'd0, ce_n0, ub_n0, lb_n0, we_n0, oe_n0}, 32'h1f);
        check_eq("reset addr", {14'd0, addr0}, 32'd0);
        check_eq("reset read_data", bus0.read_data, 32'd0);
        check_eq("reset ready", {31'd0, bus0.ready}, 32'd1);
        rst = 1'b1;

        // Store then load of one word
        access0(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, "wr1024");
        check_eq("mem word0", {16'd0, mem0[0]}, 32'h0000BEEF);
        check_eq("mem word1", {16'd0, mem0[1]}, 32'h0000DEAD);
        access0(1'b0, 1'b1, 32'd1024, 32'd0, "rd1024");

        // Both requests: store wins, load result unchanged
        access0(1'b1, 1'b1, 32'd1028, 32'h12345678, "rdwr1028");
        check_eq("mem word2", {16'd0, mem0[2]}, 32'h00005678);
        check_eq("mem word3", {16'd0, mem0[3]}, 32'h00001234);

        // One-cycle store pulse; inputs scrambled after acceptance
        exp_mem[18'd8] = 16'hF00D;
        exp_mem[18'd9] = 16'hCAFE;
        @(posedge clk); #1;
        bus0.wr_en = 1'b1; bus0.address = 32'd1040; bus0.write_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus0.wr_en = 1'b0; bus0.address = 32'd0; bus0.write_data = 32'h0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_eq("pulse ready", {31'd0, bus0.ready}, 32'd1);
        end
        repeat (2) @(posedge clk);
        check_eq("pulse mem lo", {16'd0, mem0[8]}, 32'h0000F00D);
        check_eq("pulse mem hi", {16'd0, mem0[9]}, 32'h0000CAFE);
        access0(1'b0, 1'b1, 32'd1040, 32'd0, "rd1040");

        // Address below BASE_ADDR wraps to the top of the SRAM
        access0(1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, "wr1020");
        check_eq("wrap mem lo", {16'd0, mem0[8'hFE]}, 32'h00005A5A);
        check_eq("wrap mem hi", {16'd0, mem0[8'hFF]}, 32'h0000A5A5);

        // Reset during the high phase of a load
        @(posedge clk); #1;
        bus0.rd_en = 1'b1; bus0.address = 32'd1024;
        for (int k = 0; k < 4; k++) @(negedge clk);
        check_eq("abort in HI", {14'd0, addr0}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("abort strobes", {27'd0, ce_n0, ub_n0, lb_n0, we_n0, oe_n0}, 32'h1f);
        check_eq("abort addr", {14'd0, addr0}, 32'd0);
        check_eq("abort read_data", bus0.read_data, 32'd0);
        bus0.rd_en = 1'b0;
        exp_rd = 32'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("post reset ready", {31'd0, bus0.ready}, 32'd1);
        access0(1'b0, 1'b1, 32'd1024, 32'd0, "rd after abort");

        // P = 1: loads held back-to-back, ready every 4 cycles
        sb1_q.push_back(32'h22221111);
        sb1_q.push_back(32'h44443333);
        @(posedge clk); #1;
        bus1.rd_en = 1'b1; bus1.address = 32'd1024;
        last = -1;
        pulses = 0;
        for (int k = 0; k < 40 && pulses < 2; k++) begin
            @(negedge clk);
            if (bus1.ready) begin
                check_eq("p1 ready period", 32'(k - last), 32'd4);
                check_eq("p1 read_data", bus1.read_data, sb1_q.pop_front());
                last = k;
                pulses++;
                @(posedge clk); #1;
                if (pulses == 1) bus1.address = 32'd1032;
                else bus1.rd_en = 1'b0;
            end
        end
        check_eq("p1 pulses", 32'(pulses), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
